// File: rtl/pong_input_pkg.sv
// Shared encodings for the paddle input arbiter: ownership, UART commands
// and the mode_force selector.
package pong_input_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_BTN  = 2'b01,
        OWN_UART = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        CMD_STOP    = 2'b00,
        CMD_UP      = 2'b01,
        CMD_DOWN    = 2'b10,
        CMD_RELEASE = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'b00,
        MODE_BTN    = 2'b01,
        MODE_UART   = 2'b10,
        MODE_FROZEN = 2'b11
    } mode_e;

    localparam logic PLAYER_P1 = 1'b0;

endpackage

// File: rtl/input_owner_fsm.sv
// One player's ownership FSM with the UART hold counter and the idle timer.
// Outputs are registered from next-state values so owner and direction move together.
module input_owner_fsm
    import pong_input_pkg::*;
#(
    parameter int unsigned UART_HOLD    = 2_500_000,
    parameter int unsigned IDLE_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_uart_act,
    input  logic [1:0] i_uart_cmd,
    input  logic [1:0] i_mode_force,
    output logic       o_up,
    output logic       o_down,
    output logic [1:0] o_owner
);

    localparam int unsigned HOLD_W = $clog2(UART_HOLD + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(UART_HOLD);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);

    owner_e             r_state, w_state_nx;
    logic [HOLD_W-1:0]  r_hold, w_hold_nx, w_hold_dec;
    logic [IDLE_W-1:0]  r_idle, w_idle_nx, w_idle_inc;
    logic               r_dir_down, w_dir_nx;
    logic               r_was_forced, w_forced_nx;
    logic               r_up, r_down, w_up_nx, w_down_nx;
    logic               w_btn_act, w_idle_expired, w_cmd_apply;
    mode_e              w_mode;
    cmd_e               w_cmd;

    assign w_mode         = mode_e'(i_mode_force);
    assign w_cmd          = cmd_e'(i_uart_cmd);
    assign w_btn_act      = i_btn_up | i_btn_down;
    assign w_hold_dec     = (r_hold != '0) ? r_hold - HOLD_W'(1) : '0;
    assign w_idle_inc     = (r_idle == IDLE_MAX) ? r_idle : r_idle + IDLE_W'(1);
    assign w_idle_expired = (w_idle_inc == IDLE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= OWN_NONE;
            r_hold       <= '0;
            r_idle       <= '0;
            r_dir_down   <= 1'b0;
            r_was_forced <= 1'b0;
            r_up         <= 1'b0;
            r_down       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_hold       <= w_hold_nx;
            r_idle       <= w_idle_nx;
            r_dir_down   <= w_dir_nx;
            r_was_forced <= w_forced_nx;
            r_up         <= w_up_nx;
            r_down       <= w_down_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_hold_nx   = r_hold;
        w_idle_nx   = r_idle;
        w_dir_nx    = r_dir_down;
        w_forced_nx = r_was_forced;
        w_cmd_apply = 1'b0;
        w_up_nx     = 1'b0;
        w_down_nx   = 1'b0;

        case (w_mode)
            MODE_FROZEN: begin
            end
            MODE_BTN: begin
                w_forced_nx = 1'b1;
                w_state_nx  = OWN_BTN;
                w_hold_nx   = '0;
                w_idle_nx   = '0;
            end
            MODE_UART: begin
                w_forced_nx = 1'b1;
                w_state_nx  = OWN_UART;
                w_idle_nx   = '0;
                w_hold_nx   = w_hold_dec;
                w_cmd_apply = i_uart_act;
            end
            default: begin
                w_forced_nx = 1'b0;
                // Dropping out of a forced mode always restarts arbitration from scratch.
                if (r_was_forced) begin
                    w_state_nx = OWN_NONE;
                    w_hold_nx  = '0;
                    w_idle_nx  = '0;
                end else begin
                    case (r_state)
                        OWN_BTN: begin
                            if (w_btn_act) begin
                                w_idle_nx = '0;
                            end else if (w_idle_expired) begin
                                w_state_nx = OWN_NONE;
                                w_idle_nx  = '0;
                            end else begin
                                w_idle_nx = w_idle_inc;
                            end
                        end
                        OWN_UART: begin
                            if (i_uart_act && (w_cmd == CMD_RELEASE)) begin
                                w_state_nx = OWN_NONE;
                                w_hold_nx  = '0;
                                w_idle_nx  = '0;
                            end else if (i_uart_act) begin
                                w_idle_nx   = '0;
                                w_hold_nx   = w_hold_dec;
                                w_cmd_apply = 1'b1;
                            end else if (w_idle_expired) begin
                                w_state_nx = OWN_NONE;
                                w_hold_nx  = '0;
                                w_idle_nx  = '0;
                            end else begin
                                w_idle_nx = w_idle_inc;
                                w_hold_nx = w_hold_dec;
                            end
                        end
                        default: begin
                            w_hold_nx = '0;
                            w_idle_nx = '0;
                            if (w_btn_act) begin
                                w_state_nx = OWN_BTN;
                            end else if (i_uart_act && (w_cmd != CMD_RELEASE)) begin
                                w_state_nx  = OWN_UART;
                                w_cmd_apply = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase

        if (w_cmd_apply) begin
            case (w_cmd)
                CMD_UP: begin
                    w_dir_nx  = 1'b0;
                    w_hold_nx = HOLD_LOAD;
                end
                CMD_DOWN: begin
                    w_dir_nx  = 1'b1;
                    w_hold_nx = HOLD_LOAD;
                end
                default: w_hold_nx = '0;
            endcase
        end

        if (w_mode != MODE_FROZEN) begin
            case (w_state_nx)
                OWN_BTN: begin
                    w_up_nx   = i_btn_up & ~i_btn_down;
                    w_down_nx = i_btn_down & ~i_btn_up;
                end
                OWN_UART: begin
                    w_up_nx   = (w_hold_nx != '0) && !w_dir_nx;
                    w_down_nx = (w_hold_nx != '0) && w_dir_nx;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_up    = r_up;
    assign o_down  = r_down;
    assign o_owner = r_state;

endmodule

// File: rtl/input_arbiter.sv
// Arbitrates paddle control between push-buttons and UART commands for both
// players; decodes the UART player field and instantiates one FSM per player.
module input_arbiter
    import pong_input_pkg::*;
#(
    parameter int unsigned UART_HOLD    = 2_500_000,
    parameter int unsigned IDLE_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_up,
    input  logic [1:0] btn_down,
    input  logic       uart_valid,
    input  logic [2:0] uart_cmd,
    input  logic [1:0] mode_force,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic [1:0] owner_p1,
    output logic [1:0] owner_p2
);

    if (IDLE_TIMEOUT < UART_HOLD) begin : g_param_check
        $error("input_arbiter: IDLE_TIMEOUT must be >= UART_HOLD");
    end

    logic w_p1_uart, w_p2_uart;

    assign w_p1_uart = uart_valid && (uart_cmd[2] == PLAYER_P1);
    assign w_p2_uart = uart_valid && (uart_cmd[2] != PLAYER_P1);

    input_owner_fsm #(
        .UART_HOLD    (UART_HOLD),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_p1 (
        .clk          (clk),
        .rst          (rst),
        .i_btn_up     (btn_up[0]),
        .i_btn_down   (btn_down[0]),
        .i_uart_act   (w_p1_uart),
        .i_uart_cmd   (uart_cmd[1:0]),
        .i_mode_force (mode_force),
        .o_up         (p1_up),
        .o_down       (p1_down),
        .o_owner      (owner_p1)
    );

    input_owner_fsm #(
        .UART_HOLD    (UART_HOLD),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_p2 (
        .clk          (clk),
        .rst          (rst),
        .i_btn_up     (btn_up[1]),
        .i_btn_down   (btn_down[1]),
        .i_uart_act   (w_p2_uart),
        .i_uart_cmd   (uart_cmd[1:0]),
        .i_mode_force (mode_force),
        .o_up         (p2_up),
        .o_down       (p2_down),
        .o_owner      (owner_p2)
    );

endmodule
